// File: rtl/mc_loader.sv
// mc_loader: boot-time loader and run-time fetch port for the 256 x 64-bit
// microcode control store. Packs a big-endian byte stream into 64-bit words,
// writes them with a SETUP / WRITE / REL strobe sequence, then serves
// sequencer fetches through the same RAM pins.
// Optional feature: define MC_LOADER_CHECKSUM_EN to require a trailer byte
// whose 8-bit sum with all data bytes must be zero before entering RUN.
module mc_loader #(
  parameter int WORDS    = 256,
  parameter int WR_PULSE = 1
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic [63:0] fetch_data,
  output logic        fetch_ack,
  output logic        _ram_cs,
  output logic        _ram_oe,
  output logic        _ram_w,
  output logic [7:0]  ram_addr,
  output logic [63:0] ram_wdata,
  input  logic [63:0] ram_rdata,
  output logic        loading,
  output logic        ready,
  output logic        error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_REL     = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_RUN     = 3'd6;
  localparam logic [2:0] S_FETCH   = 3'd7;

  localparam int              PW         = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [7:0]      LAST_WORD  = 8'(WORDS - 1);
  localparam logic [PW-1:0]   LAST_PULSE = PW'(WR_PULSE - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic          start_pend_q, start_pend_d;
  logic          byte_ready_q, byte_ready_d;
  logic          ram_cs_n_q, ram_cs_n_d;
  logic          ram_oe_n_q, ram_oe_n_d;
  logic          ram_w_n_q, ram_w_n_d;
  logic [7:0]    ram_addr_q, ram_addr_d;
  logic [63:0]   ram_wdata_q, ram_wdata_d;
  logic [63:0]   fetch_data_q, fetch_data_d;
  logic          fetch_ack_q, fetch_ack_d;
  logic          loading_q, loading_d;
  logic          ready_q, ready_d;
  logic          xfer_s;
  logic          begin_load_s;

`ifdef MC_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d, sum_next_s;
  logic          error_q, error_d;
  assign sum_next_s = sum_q + byte_data;
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

  // A byte moves only while the registered ready flag is offered
  assign xfer_s = byte_valid & byte_ready_q;

  // Next-state and next-output computation for loader and fetch port
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    start_pend_d = start_pend_q;
    byte_ready_d = 1'b0;
    ram_cs_n_d   = ram_cs_n_q;
    ram_oe_n_d   = ram_oe_n_q;
    ram_w_n_d    = ram_w_n_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    fetch_data_d = fetch_data_q;
    fetch_ack_d  = 1'b0;
    loading_d    = loading_q;
    ready_d      = ready_q;
    begin_load_s = 1'b0;
`ifdef MC_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    error_d      = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          begin_load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        byte_ready_d = 1'b1;
        if (xfer_s) begin
          // Shift left so the first byte ends up in [63:56]
          ram_wdata_d = {ram_wdata_q[55:0], byte_data};
          byte_cnt_d  = byte_cnt_q + 3'd1;
`ifdef MC_LOADER_CHECKSUM_EN
          sum_d       = sum_next_s;
`endif
          if (byte_cnt_q == 3'd7) begin
            state_d      = S_SETUP;
            byte_ready_d = 1'b0;
            ram_cs_n_d   = 1'b0;
            ram_w_n_d    = 1'b1;
            ram_addr_d   = word_cnt_q;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_SETUP: begin
        state_d     = S_WRITE;
        ram_w_n_d   = 1'b0;
        pulse_cnt_d = '0;
      end
      S_WRITE: begin
        if (pulse_cnt_q == LAST_PULSE) begin
          state_d   = S_REL;
          ram_w_n_d = 1'b1;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      S_REL: begin
        ram_cs_n_d = 1'b1;
        word_cnt_d = word_cnt_q + 8'd1;
        if (word_cnt_q == LAST_WORD) begin
`ifdef MC_LOADER_CHECKSUM_EN
          state_d      = S_CHECK;
          byte_ready_d = 1'b1;
`else
          state_d      = S_RUN;
          loading_d    = 1'b0;
          ready_d      = 1'b1;
`endif
        end else begin
          state_d      = S_COLLECT;
          byte_ready_d = 1'b1;
        end
      end
      S_CHECK: begin
`ifdef MC_LOADER_CHECKSUM_EN
        byte_ready_d = 1'b1;
        if (xfer_s) begin
          byte_ready_d = 1'b0;
          loading_d    = 1'b0;
          if (sum_next_s == 8'h00) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end
        end else begin
          state_d = S_CHECK;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_RUN: begin
        ram_cs_n_d = 1'b1;
        ram_oe_n_d = 1'b1;
        // A pending or fresh start wins over a fetch request
        if (start || start_pend_q) begin
          begin_load_s = 1'b1;
        end else if (fetch_req) begin
          state_d    = S_FETCH;
          ram_addr_d = fetch_addr;
          ram_cs_n_d = 1'b0;
          ram_oe_n_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FETCH: begin
        state_d      = S_RUN;
        fetch_data_d = ram_rdata;
        fetch_ack_d  = 1'b1;
        ram_cs_n_d   = 1'b1;
        ram_oe_n_d   = 1'b1;
        if (start) begin
          start_pend_d = 1'b1;
        end else begin
          start_pend_d = start_pend_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (begin_load_s) begin
      state_d      = S_COLLECT;
      word_cnt_d   = 8'd0;
      byte_cnt_d   = 3'd0;
      start_pend_d = 1'b0;
      byte_ready_d = 1'b1;
      ram_cs_n_d   = 1'b1;
      ram_oe_n_d   = 1'b1;
      ram_w_n_d    = 1'b1;
      loading_d    = 1'b1;
      ready_d      = 1'b0;
`ifdef MC_LOADER_CHECKSUM_EN
      sum_d        = 8'h00;
      error_d      = 1'b0;
`endif
    end else begin
      // values chosen in the case statement stand
    end
  end

  // State and output registers; reset discards any partial load
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 3'd0;
      word_cnt_q   <= 8'd0;
      pulse_cnt_q  <= '0;
      start_pend_q <= 1'b0;
      byte_ready_q <= 1'b0;
      ram_cs_n_q   <= 1'b1;
      ram_oe_n_q   <= 1'b1;
      ram_w_n_q    <= 1'b1;
      ram_addr_q   <= 8'd0;
      ram_wdata_q  <= 64'd0;
      fetch_data_q <= 64'd0;
      fetch_ack_q  <= 1'b0;
      loading_q    <= 1'b0;
      ready_q      <= 1'b0;
`ifdef MC_LOADER_CHECKSUM_EN
      sum_q        <= 8'h00;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      start_pend_q <= start_pend_d;
      byte_ready_q <= byte_ready_d;
      ram_cs_n_q   <= ram_cs_n_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_w_n_q    <= ram_w_n_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      fetch_data_q <= fetch_data_d;
      fetch_ack_q  <= fetch_ack_d;
      loading_q    <= loading_d;
      ready_q      <= ready_d;
`ifdef MC_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      error_q      <= error_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign _ram_cs    = ram_cs_n_q;
  assign _ram_oe    = ram_oe_n_q;
  assign _ram_w     = ram_w_n_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign fetch_data = fetch_data_q;
  assign fetch_ack  = fetch_ack_q;
  assign loading    = loading_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_mc_loader.sv
// Directed bench for mc_loader with WORDS=4, WR_PULSE=1 and a behavioural
// control-store RAM that latches on the falling edge of _ram_w.
`timescale 1ns/1ps
module tb_mc_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_addr = 8'h00;
  logic        byte_ready, fetch_ack, ram_cs_n, ram_oe_n, ram_w_n;
  logic        loading, ready, error;
  logic [7:0]  ram_addr;
  logic [63:0] fetch_data, ram_wdata, ram_rdata;

  logic [63:0] mem [0:255];
  logic [63:0] exp_word [0:3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int falls = 0;
  int wlow = 0;
  int viol = 0;
  int toggles = 0;
  logic        prev_w = 1'b1;
  logic        prev_cs = 1'b1;
  logic [7:0]  prev_addr = 8'h00;
  logic [63:0] prev_wdata = 64'h0;

`ifdef MC_LOADER_CHECKSUM_EN
  localparam int EXP_LAT = 45;
`else
  localparam int EXP_LAT = 44;
`endif

  mc_loader #(.WORDS(4), .WR_PULSE(1)) dut (
    .clk        (clk),
    ._reset     (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_ack  (fetch_ack),
    ._ram_cs    (ram_cs_n),
    ._ram_oe    (ram_oe_n),
    ._ram_w     (ram_w_n),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .loading    (loading),
    .ready      (ready),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Control-store model: combinational read, write on _ram_w fall
  assign ram_rdata = (ram_cs_n === 1'b0 && ram_oe_n === 1'b0) ? mem[ram_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
  always @(negedge ram_w_n) if (ram_cs_n === 1'b0) mem[ram_addr] = ram_wdata;

  // Any strobe edge
  always @(ram_cs_n or ram_oe_n or ram_w_n) toggles++;

  // Per-cycle strobe monitor: counts falls / low cycles, checks setup and hold
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n !== 1'b1) begin
      prev_w = 1'b1; prev_cs = 1'b1; prev_addr = 8'h00; prev_wdata = 64'h0;
    end else begin
      if (ram_w_n === 1'b0) wlow++;
      if (prev_w === 1'b1 && ram_w_n === 1'b0) begin
        falls++;
        if (prev_cs !== 1'b0 || ram_addr !== prev_addr || ram_wdata !== prev_wdata) viol++;
      end
      if (prev_w === 1'b0 && ram_w_n === 1'b1) begin
        if (ram_cs_n !== 1'b0 || ram_addr !== prev_addr || ram_wdata !== prev_wdata) viol++;
      end
      prev_w = ram_w_n; prev_cs = ram_cs_n; prev_addr = ram_addr; prev_wdata = ram_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = 64'h0;
    falls = 0; wlow = 0; viol = 0;
  endtask

  // Offer one byte until it is taken, optionally after a random idle gap
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  n;
    bit  done;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0; byte_data = 8'($urandom); tick();
      end
    end
    byte_valid = 1'b1; byte_data = b; done = 1'b0; n = 0;
    while (!done && n < 40) begin
      done = (byte_ready === 1'b1);
      tick(); n++;
    end
    byte_valid = 1'b0;
    checks++;
    if (!done) begin $display("FAIL byte_xfer byte=%h never accepted", b); errors++; end
  endtask

  // Full load of bytes 0x00..0x1F (plus trailer when checksum is built in)
  task automatic do_load(input bit gaps, input int start_at, input logic [7:0] trailer, output int lat);
    int c0, n;
    start = 1'b1; tick(); start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      if (i == start_at) begin start = 1'b1; tick(); start = 1'b0; end
      send_byte(8'(i), gaps);
    end
`ifdef MC_LOADER_CHECKSUM_EN
    send_byte(trailer, gaps);
`else
    byte_data = trailer;
`endif
    n = 0;
    while (loading === 1'b1 && n < 60) begin tick(); n++; end
    lat = cyc - c0;
    checks++;
    if (loading !== 1'b0) begin $display("FAIL load_done loading=%b want 0", loading); errors++; end
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[k] !== exp_word[k]) begin
        $display("FAIL %s mem[%0d] got %h want %h", tag, k, mem[k], exp_word[k]); errors++;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({ram_cs_n, ram_oe_n, ram_w_n, byte_ready, fetch_ack, loading, ready, error} !== 8'b1110_0000) begin
      $display("FAIL reset_ctrl got %b want 11100000", {ram_cs_n, ram_oe_n, ram_w_n, byte_ready, fetch_ack, loading, ready, error}); errors++;
    end
    checks++;
    if (ram_addr !== 8'h00 || ram_wdata !== 64'h0 || fetch_data !== 64'h0) begin
      $display("FAIL reset_data addr=%h wdata=%h fdata=%h want zeros", ram_addr, ram_wdata, fetch_data); errors++;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    toggles = 0;
    repeat (10) tick();
    checks++;
    if (toggles !== 0) begin $display("FAIL idle_toggles got %0d want 0", toggles); errors++; end
    checks++;
    if ({byte_ready, loading, ready} !== 3'b000) begin
      $display("FAIL idle_flags got %b want 000", {byte_ready, loading, ready}); errors++;
    end
  endtask

  task automatic test_load();
    int lat;
    clear_mem();
    do_load(1'b0, -1, 8'h10, lat);
    checks++;
    if (lat !== EXP_LAT) begin $display("FAIL load_latency got %0d want %0d", lat, EXP_LAT); errors++; end
    checks++;
    if (falls !== 4 || wlow !== 4) begin $display("FAIL write_pulses falls=%0d low=%0d want 4 4", falls, wlow); errors++; end
    checks++;
    if (viol !== 0) begin $display("FAIL setup_hold got %0d violations want 0", viol); errors++; end
    checks++;
    if ({ready, loading, error, byte_ready} !== 4'b1000) begin
      $display("FAIL load_flags got %b want 1000", {ready, loading, error, byte_ready}); errors++;
    end
    check_mem("load");
  endtask

  task automatic test_fetch();
    fetch_addr = 8'd2; fetch_req = 1'b1; tick();
    fetch_req = 1'b0;
    checks++;
    if (fetch_ack !== 1'b0) begin $display("FAIL fetch_early ack=%b want 0", fetch_ack); errors++; end
    tick();
    checks++;
    if (fetch_ack !== 1'b1 || fetch_data !== exp_word[2]) begin
      $display("FAIL fetch_ack ack=%b data=%h want 1 %h", fetch_ack, fetch_data, exp_word[2]); errors++;
    end
    tick();
    checks++;
    if (fetch_ack !== 1'b0 || fetch_data !== exp_word[2]) begin
      $display("FAIL fetch_hold ack=%b data=%h want 0 %h", fetch_ack, fetch_data, exp_word[2]); errors++;
    end
    // back-to-back: request held high, accepted every other cycle
    fetch_req = 1'b1; fetch_addr = 8'd0; tick();
    fetch_addr = 8'd3; tick();
    checks++;
    if (fetch_ack !== 1'b1 || fetch_data !== exp_word[0]) begin
      $display("FAIL b2b_first ack=%b data=%h want 1 %h", fetch_ack, fetch_data, exp_word[0]); errors++;
    end
    tick();
    checks++;
    if (fetch_ack !== 1'b0) begin $display("FAIL b2b_gap ack=%b want 0", fetch_ack); errors++; end
    tick();
    fetch_req = 1'b0;
    checks++;
    if (fetch_ack !== 1'b1 || fetch_data !== exp_word[3]) begin
      $display("FAIL b2b_second ack=%b data=%h want 1 %h", fetch_ack, fetch_data, exp_word[3]); errors++;
    end
    tick();
  endtask

  task automatic test_gaps();
    int lat;
    clear_mem();
    // a start pulse mid-load must be ignored
    do_load(1'b1, 13, 8'h10, lat);
    checks++;
    if (falls !== 4 || viol !== 0) begin $display("FAIL gaps_writes falls=%0d viol=%0d want 4 0", falls, viol); errors++; end
    checks++;
    if (ready !== 1'b1) begin $display("FAIL gaps_ready got %b want 1", ready); errors++; end
    check_mem("gaps");
  endtask

  task automatic test_fetch_start();
    int lat;
    bit seen;
    fetch_addr = 8'd1; fetch_req = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (fetch_ack !== 1'b1 || fetch_data !== exp_word[1] || {loading, ready} !== 2'b01) begin
      $display("FAIL fs_ack ack=%b data=%h ld/rdy=%b want 1 %h 01", fetch_ack, fetch_data, {loading, ready}, exp_word[1]); errors++;
    end
    tick();
    checks++;
    if (fetch_ack !== 1'b0 || {loading, ready} !== 2'b10) begin
      $display("FAIL fs_reload ack=%b ld/rdy=%b want 0 10", fetch_ack, {loading, ready}); errors++;
    end
    seen = 1'b0;
    repeat (4) begin tick(); if (fetch_ack !== 1'b0) seen = 1'b1; end
    fetch_req = 1'b0;
    checks++;
    if (seen) begin $display("FAIL fs_no_fetch ack seen=1 want 0"); errors++; end
    clear_mem();
    do_load(1'b0, -1, 8'h10, lat);
    check_mem("fs_reload");
    // start and fetch_req together in RUN: reload wins, no ack
    fetch_addr = 8'd2; fetch_req = 1'b1; start = 1'b1; tick();
    start = 1'b0; fetch_req = 1'b0;
    checks++;
    if ({loading, ready} !== 2'b10) begin $display("FAIL prio_reload ld/rdy=%b want 10", {loading, ready}); errors++; end
    tick();
    checks++;
    if (fetch_ack !== 1'b0) begin $display("FAIL prio_ack ack=%b want 0", fetch_ack); errors++; end
    do_load(1'b0, -1, 8'h10, lat);
    checks++;
    if (ready !== 1'b1) begin $display("FAIL prio_ready got %b want 1", ready); errors++; end
  endtask

  task automatic test_reset_mid_write();
    int n, lat;
    clear_mem();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    n = 0;
    while (!(ram_w_n === 1'b0 && ram_addr === 8'd1) && n < 10) begin tick(); n++; end
    checks++;
    if (n >= 10) begin $display("FAIL mw_reach w=%b addr=%h want 0 01", ram_w_n, ram_addr); errors++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_cs_n, ram_oe_n, ram_w_n, byte_ready, fetch_ack, loading, ready, error} !== 8'b1110_0000) begin
      $display("FAIL mw_ctrl got %b want 11100000", {ram_cs_n, ram_oe_n, ram_w_n, byte_ready, fetch_ack, loading, ready, error}); errors++;
    end
    checks++;
    if (ram_addr !== 8'h00 || ram_wdata !== 64'h0 || fetch_data !== 64'h0) begin
      $display("FAIL mw_data addr=%h wdata=%h fdata=%h want zeros", ram_addr, ram_wdata, fetch_data); errors++;
    end
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
    clear_mem();
    do_load(1'b0, -1, 8'h10, lat);
    checks++;
    if (lat !== EXP_LAT || falls !== 4 || ready !== 1'b1) begin
      $display("FAIL mw_fresh lat=%0d falls=%0d ready=%b want %0d 4 1", lat, falls, ready, EXP_LAT); errors++;
    end
    check_mem("mw_fresh");
  endtask

`ifdef MC_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int lat;
    bit seen;
    do_load(1'b0, -1, 8'h11, lat);
    checks++;
    if ({error, ready, loading} !== 3'b100) begin
      $display("FAIL cks_fail err/rdy/ld=%b want 100", {error, ready, loading}); errors++;
    end
    seen = 1'b0;
    fetch_addr = 8'd0; fetch_req = 1'b1;
    repeat (4) begin tick(); if (fetch_ack !== 1'b0) seen = 1'b1; end
    fetch_req = 1'b0;
    checks++;
    if (seen) begin $display("FAIL cks_fetch ack seen=1 want 0"); errors++; end
    do_load(1'b0, -1, 8'h10, lat);
    checks++;
    if ({error, ready} !== 2'b01) begin $display("FAIL cks_pass err/rdy=%b want 01", {error, ready}); errors++; end
  endtask
`endif

  initial begin
    exp_word[0] = 64'h0001020304050607;
    exp_word[1] = 64'h08090A0B0C0D0E0F;
    exp_word[2] = 64'h1011121314151617;
    exp_word[3] = 64'h18191A1B1C1D1E1F;
    test_reset();
    test_load();
    test_fetch();
    test_gaps();
    test_fetch_start();
    test_reset_mid_write();
`ifdef MC_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
